// File: rtl/core_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_div_pkg
// Description : Shared encodings, FSM state type and iteration-count helper
//               for the iterative radix-2 divider.
// Revision    : 1.0 - initial release
// ============================================================================
package core_div_pkg;

  // Operation encoding on the control bus. Bit 1 selects remainder, and
  // bit 0 selects unsigned.
  localparam logic [1:0] c_div_op   = 2'b00;
  localparam logic [1:0] c_divu_op  = 2'b01;
  localparam logic [1:0] c_rem_op   = 2'b10;
  localparam logic [1:0] c_remu_op  = 2'b11;

  // W-form aliases. They use the same encodings, and isword qualifies them.
  localparam logic [1:0] c_divw_op  = c_div_op;
  localparam logic [1:0] c_divuw_op = c_divu_op;
  localparam logic [1:0] c_remw_op  = c_rem_op;
  localparam logic [1:0] c_remuw_op = c_remu_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Number of quotient bits to develop. A word operation only walks the low half.
  function automatic int unsigned div_iter_count(input logic isword, input int unsigned xlen);
    return isword ? (xlen / 2) : xlen;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_div_out.sv
`default_nettype none
// ============================================================================
// Module      : core_div_out
// Description : Result shaping for the divider. It handles sign correction,
//               divide-by-zero substitution and W-form sign extension.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module core_div_out #(
  parameter int XLEN = 64
) (
  input  logic [1:0]      i_control,
  input  logic            i_isword,
  input  logic            i_sign_a,
  input  logic            i_sign_b,
  input  logic            i_div_zero,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_rem,
  output logic [XLEN-1:0] o_result
);

  localparam int c_HALF = XLEN / 2;

  logic            w_is_rem;
  logic            w_signed;
  logic            w_neg;
  logic [XLEN-1:0] w_mag;
  logic [XLEN-1:0] w_fix;
  logic [XLEN-1:0] w_sel;

  // Pick the magnitude, then apply the sign. Divide by zero bypasses the
  // datapath. The word form sign-extends from the low half.
  always_comb begin
    w_is_rem = i_control[1];
    w_signed = ~i_control[0];
    w_mag    = w_is_rem ? i_rem : i_quo;
    // The quotient sign is signA^signB. The remainder follows the dividend.
    w_neg    = w_signed & (w_is_rem ? i_sign_a : (i_sign_a ^ i_sign_b));
    // A most-negative overflow magnitude negates onto itself, so it needs no special path.
    w_fix    = w_neg ? (-w_mag) : w_mag;
    if (i_div_zero)
      w_sel = w_is_rem ? i_src_a : {XLEN{1'b1}};
    else
      w_sel = w_fix;
    if (i_isword)
      o_result = {{c_HALF{w_sel[c_HALF-1]}}, w_sel[c_HALF-1:0]};
    else
      o_result = w_sel;
  end

endmodule
`default_nettype wire

// File: rtl/core_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : core_div_iter
// Description : Sequential radix-2 restoring divider. It develops one
//               quotient bit per cycle from pre-conditioned magnitudes and
//               returns the quotient or remainder with a busy/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module core_div_iter
  import core_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_iter_start,
  input  logic            i_div_iter_flush,
  input  logic [1:0]      i_div_iter_control,
  input  logic            i_div_iter_isword,
  input  logic [XLEN-1:0] i_div_iter_srcA,
  input  logic [XLEN-1:0] i_div_iter_srcB,
  input  logic [XLEN-1:0] i_div_iter_dividend,
  input  logic [XLEN-1:0] i_div_iter_divisor,
  output logic            o_div_iter_busy,
  output logic            o_div_iter_valid,
  output logic [XLEN-1:0] o_div_iter_result
);

  localparam int c_HALF = XLEN / 2;
  localparam int c_CW   = $clog2(XLEN + 1);

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [c_CW-1:0] r_count;
  logic [1:0]      r_control;
  logic            r_isword;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_div_zero;
  logic [XLEN-1:0] r_src_a;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic [XLEN-1:0] w_dividend_in;
  logic [XLEN-1:0] w_divisor_in;
  logic            w_divisor_zero;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_valid;
  logic [XLEN-1:0] w_out;
  logic            w_unused_src_b;

  // Only the sign bits of rs2 matter here. The divisor magnitude arrives separately.
  assign w_unused_src_b = ^i_div_iter_srcB;

  // Conditioning of the launch operands. A word op keeps only the low half.
  // That half still holds the correct magnitude even when upstream negated the
  // full-width value.
  always_comb begin
    w_accept       = (r_state == IDLE) && i_div_iter_start && !i_div_iter_flush;
    w_dividend_in  = i_div_iter_isword ? {{c_HALF{1'b0}}, i_div_iter_dividend[c_HALF-1:0]}
                                       : i_div_iter_dividend;
    w_divisor_in   = i_div_iter_isword ? {{c_HALF{1'b0}}, i_div_iter_divisor[c_HALF-1:0]}
                                       : i_div_iter_divisor;
    w_divisor_zero = (w_divisor_in == '0);
    // Trial subtract one bit wider than XLEN. The top bit is the borrow.
    w_shift        = {r_rem, r_quo[XLEN-1]};
    w_trial        = w_shift - {1'b0, r_divisor};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. A flush returns to IDLE from any active state and wins over start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_divisor_zero ? DONE : CALC;
      CALC: begin
        if (i_div_iter_flush)              w_state_nxt = IDLE;
        else if (r_count == c_CW'(1))      w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture at launch, then one restoring step per CALC cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_control  <= '0;
      r_isword   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_src_a    <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
    end else if (w_accept) begin
      r_count    <= c_CW'(div_iter_count(i_div_iter_isword, XLEN));
      r_control  <= i_div_iter_control;
      r_isword   <= i_div_iter_isword;
      r_sign_a   <= i_div_iter_isword ? i_div_iter_srcA[c_HALF-1] : i_div_iter_srcA[XLEN-1];
      r_sign_b   <= i_div_iter_isword ? i_div_iter_srcB[c_HALF-1] : i_div_iter_srcB[XLEN-1];
      r_div_zero <= w_divisor_zero;
      r_src_a    <= i_div_iter_srcA;
      r_divisor  <= w_divisor_in;
      r_rem      <= '0;
      // Word dividends are pre-shifted to the top so that the MSB-first walk
      // reaches their bits within the shorter iteration count.
      r_quo      <= i_div_iter_isword ? {w_dividend_in[c_HALF-1:0], {c_HALF{1'b0}}}
                                      : w_dividend_in;
    end else if (r_state == CALC) begin
      r_count <= r_count - c_CW'(1);
      if (!w_trial[XLEN]) begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  core_div_out #(
    .XLEN (XLEN)
  ) u_out (
    .i_control  (r_control),
    .i_isword   (r_isword),
    .i_sign_a   (r_sign_a),
    .i_sign_b   (r_sign_b),
    .i_div_zero (r_div_zero),
    .i_src_a    (r_src_a),
    .i_quo      (r_quo),
    .i_rem      (r_rem),
    .o_result   (w_out)
  );

  // Completion is a flush-qualified DONE. The result register holds the last
  // delivered value between completions.
  assign w_valid = (r_state == DONE) && !i_div_iter_flush;

  // Result register, updated only on a delivered completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_result <= '0;
    else if (w_valid) r_result <= w_out;
  end

  assign o_div_iter_busy   = (r_state != IDLE);
  assign o_div_iter_valid  = w_valid;
  assign o_div_iter_result = w_valid ? w_out : r_result;

endmodule
`default_nettype wire

// File: tb/tb_core_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_div_iter
// Description : Scoreboard bench for core_div_iter. It uses directed vectors
//               with hand-computed results and launch-relative completion cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_div_iter;
  import core_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  control;
  logic        isword;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        valid;
  logic [63:0] result;

  core_div_iter #(.XLEN(64)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_div_iter_start    (start),
    .i_div_iter_flush    (flush),
    .i_div_iter_control  (control),
    .i_div_iter_isword   (isword),
    .i_div_iter_srcA     (src_a),
    .i_div_iter_srcB     (src_b),
    .i_div_iter_dividend (dividend),
    .i_div_iter_divisor  (divisor),
    .o_div_iter_busy     (busy),
    .o_div_iter_valid    (valid),
    .o_div_iter_result   (result)
  );

  always #5 clk = ~clk;

  int cycle_num = 0;
  always @(posedge clk) cycle_num = cycle_num + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_result = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: cycle %0d result 0x%h, expected no pulse", cycle_num, result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, 64'(cycle_num), 64'(e.cyc));
      end
    end
  end

  // Drive one start pulse. n is the iteration count, so completion is
  // expected at launch+n+1.
  task automatic issue(input string name, input logic [1:0] ctrl, input logic isw,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] dd, input logic [63:0] dv,
                       input logic [63:0] exp, input int n, input bit push);
    exp_t e;
    control  = ctrl;
    isword   = isw;
    src_a    = a;
    src_b    = b;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    if (push) begin
      e.res  = exp;
      e.cyc  = cycle_num + n + 1;
      e.name = name;
      sb.push_back(e);
      last_result = exp;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) begin
      @(posedge clk); #1;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1, expected 0 within 300 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 300 && !valid; i++) begin
      @(posedge clk); #1;
    end
    if (!valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: valid still 0, expected 1 within 300 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; control = '0; isword = 1'b0;
    src_a = '0; src_b = '0; dividend = '0; divisor = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_busy",   64'(busy),  64'(0));
    check("reset_valid",  64'(valid), 64'(0));
    check("reset_result", result,     64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed and unsigned 64-bit operations.
    issue("div_m20_3", c_div_op, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd20, 64'd3,
          64'hFFFF_FFFF_FFFF_FFFA, 64, 1'b1);
    wait_idle("div_m20_3");
    check("hold_after_div", result, last_result);
    issue("rem_m20_3", c_rem_op, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd20, 64'd3,
          64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1);
    wait_idle("rem_m20_3");
    issue("remu_100_7", c_remu_op, 1'b0, 64'd100, 64'd7, 64'd100, 64'd7, 64'd2, 64, 1'b1);
    wait_idle("remu_100_7");

    // Divide by zero completes one cycle after launch.
    issue("divu_5_0", c_divu_op, 1'b0, 64'd5, 64'd0, 64'd5, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    wait_idle("divu_5_0");
    issue("rem_m7_0", c_rem_op, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'd7, 64'd0,
          64'hFFFF_FFFF_FFFF_FFF9, 0, 1'b1);
    wait_idle("rem_m7_0");
    issue("remw_x_0", c_remw_op, 1'b1, 64'h1234_5678_8000_0001, 64'd0,
          64'hEDCB_A987_7FFF_FFFF, 64'h0, 64'hFFFF_FFFF_8000_0001, 0, 1'b1);
    wait_idle("remw_x_0");

    // Overflow cases.
    issue("div_ovf", c_div_op, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 64, 1'b1);
    wait_idle("div_ovf");
    issue("rem_ovf", c_rem_op, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd1, 64'h0, 64, 1'b1);
    wait_idle("rem_ovf");
    issue("divw_ovf", c_divw_op, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32, 1'b1);
    wait_idle("divw_ovf");

    // Word ops must ignore the upper operand halves.
    issue("divuw_100_7", c_divuw_op, 1'b1, 64'h0000_0001_0000_0064, 64'h0000_0005_0000_0007,
          64'h0000_0001_0000_0064, 64'h0000_0005_0000_0007, 64'd14, 32, 1'b1);
    wait_idle("divuw_100_7");
    issue("remw_m20_3", c_remw_op, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd20, 64'd3,
          64'hFFFF_FFFF_FFFF_FFFE, 32, 1'b1);
    wait_idle("remw_m20_3");

    // Flush at launch+10: no pulse, and the held result is unchanged.
    // A new op then starts right away.
    issue("flushed", c_divu_op, 1'b0, 64'd1000, 64'd10, 64'd1000, 64'd10, 64'd0, 64, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",   64'(busy), 64'(0));
    check("flush_result", result,    last_result);
    issue("divu_9_3", c_divu_op, 1'b0, 64'd9, 64'd3, 64'd9, 64'd3, 64'd3, 64, 1'b1);
    wait_idle("divu_9_3");

    // An asynchronous reset in the middle of an operation.
    issue("reset_mid", c_divu_op, 1'b0, 64'd77, 64'd7, 64'd77, 64'd7, 64'd0, 64, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_busy",   64'(busy),  64'(0));
    check("midrst_valid",  64'(valid), 64'(0));
    check("midrst_result", result,     64'h0);
    last_result = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back launch, plus a start that is ignored while busy.
    issue("b2b_first", c_divu_op, 1'b0, 64'd100, 64'd7, 64'd100, 64'd7, 64'd14, 64, 1'b1);
    wait_valid("b2b_first");
    @(posedge clk); #1;
    issue("b2b_second", c_remu_op, 1'b0, 64'd100, 64'd7, 64'd100, 64'd7, 64'd2, 64, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    issue("ignored", c_divu_op, 1'b0, 64'd50, 64'd5, 64'd50, 64'd5, 64'd0, 64, 1'b0);
    wait_idle("b2b_second");

    repeat (5) begin @(posedge clk); #1; end
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_div_iter.md
Name: core_div_iter

Overview:
- Sequential radix-2 restoring divider. It sits directly downstream of the divider input-conditioning stage and consumes the unsigned dividend/divisor magnitudes that stage produces.
- Runs one quotient bit per cycle and applies RISC-V M-extension sign correction, divide-by-zero rules and word-result sign extension.
- Returns a single XLEN result (quotient or remainder) to the execute stage with a busy/valid handshake.

Parameters:
- XLEN, 64, datapath width; word ops use XLEN/2.

Ports:
- i_clk  input  1  core clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_div_iter_start  input  1  launch request; sampled only in IDLE
- i_div_iter_flush  input  1  abort the current operation (pipeline kill)
- i_div_iter_control  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (W variants when isword=1)
- i_div_iter_isword  input  1  32-bit W-form operation
- i_div_iter_srcA  input  XLEN  raw rs1, used for signs and special cases
- i_div_iter_srcB  input  XLEN  raw rs2, used for signs and special cases
- i_div_iter_dividend  input  XLEN  magnitude from the input-conditioning stage
- i_div_iter_divisor  input  XLEN  magnitude from the input-conditioning stage
- o_div_iter_busy  output  1  high in CALC and DONE
- o_div_iter_valid  output  1  one-cycle completion pulse
- o_div_iter_result  output  XLEN  final result; held until the next completion

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst is asynchronous, active-high. While reset is asserted: state=IDLE, busy=0, valid=0, result=0, counter=0, internal registers=0. Reset mid-operation discards the operation silently.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 (cycle t), latch control, isword, the srcA/srcB sign bits, and the magnitudes.
  - In word mode, mask the magnitudes to the low XLEN/2 bits. The upstream stage may negate the full XLEN value; the low half is still the correct magnitude, including 2^31.
  - Clear the partial remainder and load N=XLEN, or XLEN/2 when isword=1.
  - If the latched divisor magnitude is zero, go straight to DONE. Otherwise go to CALC.
- CALC:
  - Each cycle: shift {rem, quo} left by 1; trial = rem - divisor; if there is no borrow, rem = trial and the quotient LSB = 1.
  - The counter decrements and CALC→DONE when it reaches 1, so exactly N iterations are performed.
  - The trial subtract is XLEN+1 bits wide to hold the borrow.
- DONE (one cycle): valid=1, result registered, next state IDLE.
- Latency: normal valid at cycle t+N+1 (t+65 for 64-bit, t+33 for word). Divide-by-zero valid at t+1.
- signed = control[0]==0. Sign source is bit XLEN-1, or bit XLEN/2-1 of the raw srcA/srcB when isword=1.
- Quotient (control[1]==0):
  - Divisor zero: all ones.
  - Otherwise negate the magnitude if signed and signA != signB.
- Remainder (control[1]==1):
  - Divisor zero: srcA (low word when isword=1).
  - Otherwise negate the magnitude if signed and signA=1.
- Overflow (most-negative / -1) needs no special path: magnitude 2^(N-1) negates to itself; remainder is 0.
- Word result: low XLEN/2 bits sign-extended from bit XLEN/2-1, for all four W ops.
- Flush:
  - In CALC or DONE, the next state is IDLE with no valid pulse; result keeps its previous value.
  - Flush overrides start in the same cycle.
  - Flush in IDLE has no effect.
- Start while busy is ignored; the producer must wait for busy=0.
- Start is accepted in the cycle after DONE (back-to-back); the minimum issue interval is N+2.

Decomposition:
- Package core_div_pkg:
  - control encodings DIV/DIVU/REM/REMU (and W aliases);
  - state enum div_state_e {IDLE, CALC, DONE};
  - a function returning the iteration count for isword.
- Sub-module core_div_out: combinational sign correction, divide-by-zero substitution and word sign extension, feeding the result register. The iteration datapath and FSM stay in core_div_iter.

Test Plan:
- DIV, srcA=-20, srcB=3, magnitudes 20/3, start at cycle 0 → valid pulse at cycle 65 only, result 0xFFFF_FFFF_FFFF_FFFA (-6); busy high cycles 1-65.
- REM, same operands → -2 (0xFFFF_FFFF_FFFF_FFFE). REMU 100/7 → 2 at cycle 65.
- Divide by zero:
  - DIVU 5/0 → all ones at cycle 1.
  - REM srcA=-7, divisor 0 → 0xFFFF_FFFF_FFFF_FFF9 at cycle 1.
  - REMW srcA=0x1234_5678_8000_0001, 0 → 0xFFFF_FFFF_8000_0001.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM → 0.
  - DIVW srcA=0x0000_0000_8000_0000, srcB=-1 → 0xFFFF_FFFF_8000_0000, valid at cycle 33.
- Flush and reset:
  - Flush at cycle 10 → busy=0 at cycle 11, no valid, result unchanged.
  - Then start DIVU 9/3 at cycle 11 → result 3 at cycle 76.
  - Asserting i_rst at cycle 20 of an operation clears busy/valid/result to 0 immediately (asynchronous).
- Back-to-back: a second start in the cycle after valid is accepted and completes at +65. A start pulsed while busy is ignored (no extra valid).
